// File: rtl/seq_booth_multiplier_if.sv
// seq_booth_multiplier_if: operand/result handshake bundle for the sequential Booth multiplier
interface seq_booth_multiplier_if #(parameter int SIZE = 64);
  logic            start;
  logic [1:0]      mult_mode;
  logic [SIZE-1:0] multiplicand;
  logic [SIZE-1:0] multiplier;
  logic [SIZE-1:0] result;
  logic            done;
  logic            stall;
  modport master (output start, mult_mode, multiplicand, multiplier, input result, done, stall);
  modport slave (input start, mult_mode, multiplicand, multiplier, output result, done, stall);
endinterface

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: multi-cycle radix-4 Booth MUL/UMULH/SMULH; optional MULT_ZERO_BYPASS_EN skips iterations on zero operands
module seq_booth_multiplier #(
  parameter int SIZE = 64
) (
  input logic                    clk,
  input logic                    reset,
  seq_booth_multiplier_if.slave  bus
);
  localparam int ITERS = (SIZE + 2) / 2;
  localparam int CW = $clog2(ITERS + 1);
  localparam int W = SIZE + 2;
  localparam int PW = 2 * SIZE + 5;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] prod;
  logic [W-1:0] a_reg;
  logic [1:0] mode;
  logic carry;
  logic [SIZE-1:0] result_q;
  logic accept, zero, signed_op, last;
  logic [W-1:0] a_in, b_in;
  logic [SIZE+2:0] a3, addend, sum;
  logic [2:0] sel;
  logic signed [PW-1:0] pre_shift;
  logic [PW-1:0] next_prod;
  assign accept = bus.start && state != ITER;
  assign last = cnt == CW'(1);
`ifdef MULT_ZERO_BYPASS_EN
  assign zero = accept && (bus.multiplicand == '0 || bus.multiplier == '0);
`else
  assign zero = 1'b0;
`endif
  assign signed_op = bus.mult_mode == 2'b10;
  assign a_in = signed_op ? {{2{bus.multiplicand[SIZE-1]}}, bus.multiplicand} : {2'b00, bus.multiplicand};
  assign b_in = signed_op ? {{2{bus.multiplier[SIZE-1]}}, bus.multiplier} : {2'b00, bus.multiplier};
  assign sel = {prod[1:0], carry};
  assign a3 = {a_reg[W-1], a_reg};
  // Booth digit selection and one add/shift step on the product register
  always_comb begin
    addend = (sel == 3'b001 || sel == 3'b010) ? a3 :
             (sel == 3'b011) ? a3 << 1 :
             (sel == 3'b100) ? -(a3 << 1) :
             (sel == 3'b101 || sel == 3'b110) ? -a3 : '0;
    sum = prod[PW-1:W] + addend;
    pre_shift = {sum, prod[W-1:0]};
    next_prod = pre_shift >>> 2;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next-state logic: ITER runs until the counter's last step; start is only honoured outside ITER
  always_comb begin
    state_n = state;
    if (state == ITER) state_n = last ? DONE : ITER;
    else state_n = bus.start ? (zero ? DONE : ITER) : IDLE;
  end
  // datapath: operand latch on accept, Booth iteration, result capture on the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      a_reg <= '0;
      mode <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result_q <= '0;
    end else if (accept) begin
      mode <= bus.mult_mode;
      a_reg <= a_in;
      prod <= {{(SIZE + 3){1'b0}}, b_in};
      carry <= 1'b0;
      cnt <= CW'(ITERS);
      if (zero) result_q <= '0;
    end else if (state == ITER) begin
      prod <= next_prod;
      carry <= prod[1];
      cnt <= cnt - CW'(1);
      if (last) result_q <= (mode == 2'b01 || mode == 2'b10) ? next_prod[2*SIZE-1:SIZE] : next_prod[SIZE-1:0];
    end
  end
  assign bus.result = result_q;
  assign bus.done = state == DONE;
  assign bus.stall = state == ITER;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: table-driven and hand-sequenced checks of the Booth multiplier
module tb_seq_booth_multiplier;
  localparam int SIZE = 64;
  localparam int LAT = 34;
  localparam int STALLS = 33;
  typedef struct {
    logic [1:0]      mode;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  seq_booth_multiplier_if #(.SIZE(SIZE)) bus ();
  seq_booth_multiplier #(.SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [1:0] m, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       output logic [SIZE-1:0] r, output int lat, output int st);
    bus.start = 1'b1;
    bus.mult_mode = m;
    bus.multiplicand = a;
    bus.multiplier = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mult_mode = 2'($urandom);
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier = {$urandom, $urandom};
    lat = 1;
    st = 0;
    while (!bus.done && lat < 200) begin
      if (bus.stall) st++;
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.result;
  endtask
  initial begin
    vec_t vecs[8];
    logic [SIZE-1:0] r;
    int lat, st, dones;
    vecs[0] = '{2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[3] = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[4] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[5] = '{2'b11, 64'd5, 64'd6, 64'd30};
    vecs[6] = '{2'b01, 64'h8000_0000_0000_0000, 64'd2, 64'd1};
    vecs[7] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    bus.start = 1'b0;
    bus.mult_mode = 2'b00;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].mode, vecs[i].a, vecs[i].b, r, lat, st);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("vec%0d_stalls", i), 64'(st), 64'(STALLS));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
    end
    bus.start = 1'b1;
    bus.mult_mode = 2'b00;
    bus.multiplicand = 64'd3;
    bus.multiplier = 64'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mult_mode = 2'b01;
    bus.multiplicand = 64'd100;
    bus.multiplier = 64'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    r = '1;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        dones++;
        r = bus.result;
      end
      @(posedge clk);
      #1;
    end
    chk("mid_iter_result", r, 64'd15);
    chk("mid_iter_done_count", 64'(dones), 64'd1);
    bus.start = 1'b1;
    bus.mult_mode = 2'b00;
    bus.multiplicand = 64'd2;
    bus.multiplier = 64'd3;
    @(posedge clk);
    #1;
    bus.multiplicand = 64'd4;
    bus.multiplier = 64'd5;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_first_result", bus.result, 64'd6);
    chk("b2b_first_latency", 64'(lat), 64'(LAT));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_restart_stall", 64'(bus.stall), 64'd1);
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_second_result", bus.result, 64'd20);
    chk("b2b_second_latency", 64'(lat), 64'(LAT));
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mult_mode = 2'b00;
    bus.multiplicand = 64'd9;
    bus.multiplier = 64'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_stall", 64'(bus.stall), 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    chk("midreset_result", bus.result, 64'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("midreset_no_done", 64'(dones), 64'd0);
    do_op(2'b00, 64'd12, 64'd12, r, lat, st);
    chk("post_reset_result", r, 64'd144);
    chk("post_reset_latency", 64'(lat), 64'(LAT));
    @(posedge clk);
    #1;
    do_op(2'b00, 64'd0, 64'h1234, r, lat, st);
    chk("zero_result", r, 64'd0);
`ifdef MULT_ZERO_BYPASS_EN
    chk("zero_latency", 64'(lat), 64'd1);
    chk("zero_stalls", 64'(st), 64'd0);
`else
    chk("zero_latency", 64'(lat), 64'(LAT));
    chk("zero_stalls", 64'(st), 64'(STALLS));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
- Multi-cycle radix-4 Booth multiplier for the execute stage. Serves MUL, UMULH and SMULH.
- Parametrised operand width, with correct signed and unsigned high-half results.
- Registered result and a one-cycle done pulse.
- Stall output freezes the pipeline while an operation is in flight.

Parameters:
- SIZE, default 64 (`WORD): operand and result width. Must be even and at least 4.
- ITERS, default (SIZE+2)/2: number of Booth iteration cycles. Derived locally; not overridable.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a new operation. Sampled only in IDLE or DONE.
- mult_mode, input, 2: 00 MUL (low half), 01 UMULH (unsigned high), 10 SMULH (signed high), 11 treated as MUL.
- multiplicand, input, SIZE: operand A, sampled on the accepting edge.
- multiplier, input, SIZE: operand B, sampled on the accepting edge.
- result, output, SIZE: registered result. Held until the next completion.
- done, output, 1: one-cycle completion pulse.
- stall, output, 1: high while in ITER.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: result=0, done=0, stall=0, state=IDLE. Counter, accumulator and latched mode are cleared.
- Reset mid-operation: the operation is aborted. No done pulse; result keeps its reset value of 0.
- States:
  - IDLE: on start, go to ITER.
  - ITER: on every cycle, do one Booth step and decrement the counter. When the counter reaches 1, go to DONE.
  - DONE: done=1 for exactly this cycle. With start, go to ITER (back-to-back); otherwise go to IDLE.
- Accept (start in IDLE or DONE):
  - Latch mult_mode.
  - Extend both operands to SIZE+2 bits: sign-extend for 10, zero-extend for 00, 01 and 11.
  - Load the product register as {zero accumulator, extended multiplier}. Clear the Booth carry bit. Set counter=ITERS.
- Booth step:
  - Examine {product[1:0], carry}. Add or subtract 0, ±A or ±2A into the accumulator. The accumulator is SIZE+3 bits wide, so 2A never overflows.
  - Set carry=product[1], then arithmetic-shift the product right by 2.
- Capture on the final step: result is written on the ITER->DONE edge, in the same cycle done asserts.
  - Mode 00/11: result = full product[SIZE-1:0].
  - Mode 01/10: result = full product[2*SIZE-1:SIZE].
- Latency: start is accepted at edge 0. done is high in the cycle after edge ITERS. For SIZE=64 that is 33 stall cycles, then done.
- Handshake:
  - start during ITER is ignored and has no effect on the in-flight operation.
  - Operands and mult_mode may change freely after the accepting edge.
  - stall goes high on the edge after accept and falls on the edge that enters DONE.
- Arithmetic: exact for all operand values, including -2^(SIZE-1) in either operand under SMULH, and all-ones under UMULH.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined: at accept, if multiplicand==0 or multiplier==0, go directly to DONE. result=0 is written on that edge, done pulses the next cycle, and stall never asserts.
- Undefined: zero operands take the full ITERS cycles and produce 0. No comparator logic is synthesised.

Test Plan:
- Signed MUL: SIZE=64, MUL, A=7, B=0xFFFF_FFFF_FFFF_FFFD (-3) -> result 0xFFFF_FFFF_FFFF_FFEB; done exactly 34 cycles after the start edge; stall high for 33 cycles.
- UMULH all-ones: UMULH, A=B=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE. Same operands with MUL -> 0x0000_0000_0000_0001.
- SMULH extremes:
  - A=B=0x8000_0000_0000_0000 -> result 0x4000_0000_0000_0000.
  - A=B=0xFFFF_FFFF_FFFF_FFFF -> result 0.
- Handshake:
  - start pulsed again mid-ITER with different operands -> first result is unaffected and there is one done pulse only.
  - start held high in DONE -> next operation begins immediately and its done pulses 34 cycles later.
- Reset mid-operation: assert reset at iteration 10 -> next cycle shows stall=0, done=0, result=0. A fresh op after reset (MUL 12×12) -> 144.
- Zero bypass: A=0, B=0x1234.
  - MULT_ZERO_BYPASS_EN defined: done on the cycle after accept, stall never high, result 0.
  - Undefined: done after 34 cycles, result 0.
